// File: rtl/result_tx_formatter.sv
// Formats a 12-bit {remainder, quotient} divider result as "QQRrr\r\n" in ASCII
// and hands it to the UART transmitter one byte at a time.
module result_tx_formatter (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        alu_done,
    input  logic [11:0] result,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd6;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [11:0] res_q, res_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic        ovr_q, ovr_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // High digits only carry two bits of the 6-bit field, so they top out at '3'.
    function automatic logic [7:0] char_at(input logic [2:0] idx, input logic [11:0] res);
        case (idx)
            3'd0:    return hex_char({2'b00, res[5:4]});
            3'd1:    return hex_char(res[3:0]);
            3'd2:    return 8'h52;
            3'd3:    return hex_char({2'b00, res[11:10]});
            3'd4:    return hex_char(res[9:6]);
            3'd5:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            res_q      <= 12'h000;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            res_q      <= res_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        res_d      = res_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        ovr_d      = ovr_q;

        // busy_q is still high on the WAIT_DONE->IDLE edge, so a result landing
        // on that edge is dropped and flagged like any other mid-line arrival.
        if (alu_done && busy_q) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (alu_done) begin
                    res_d   = result;
                    idx_d   = 3'd0;
                    ovr_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = char_at(idx_q, res_q);
                    tx_start_d = 1'b1;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_result_tx_formatter.sv
// Directed bench for result_tx_formatter with a simple UART TX busy model.
module tb_result_tx_formatter;

    logic        clk;
    logic        n_rst;
    logic        alu_done;
    logic [11:0] result;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        overrun;

    logic        mbusy;
    logic        hold_busy;
    int          ack_dly;
    logic [7:0]  rx_q[$];
    int          stab_viol;
    int          pulse_viol;
    int          pulses;

    int checks;
    int errors;

    assign tx_busy = mbusy | hold_busy;

    result_tx_formatter dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .alu_done (alu_done),
        .result   (result),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: capture byte on tx_start, raise busy after ack_dly edges, hold 10 cycles.
    initial begin
        logic [7:0] cap;
        mbusy     = 1'b0;
        stab_viol = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_start) begin
                cap = tx_data;
                rx_q.push_back(cap);
                for (int i = 0; i < ack_dly; i++) begin
                    @(posedge clk);
                    #1;
                    if (tx_data !== cap) stab_viol++;
                end
                mbusy = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                mbusy = 1'b0;
            end
        end
    end

    // Pulse protocol monitor: no start while busy, no two starts without a busy fall.
    initial begin
        logic prev_busy;
        logic since;
        prev_busy  = 1'b0;
        since      = 1'b0;
        pulses     = 0;
        pulse_viol = 0;
        forever begin
            @(negedge clk);
            if (prev_busy && !tx_busy) since = 1'b0;
            if (tx_start) begin
                pulses++;
                if (tx_busy) pulse_viol++;
                if (since) pulse_viol++;
                since = 1'b1;
            end
            prev_busy = tx_busy;
        end
    end

    task automatic start_line(input logic [11:0] r);
        @(posedge clk);
        #1;
        result   = r;
        alu_done = 1'b1;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (rx_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({tx_start, tx_data, busy, overrun} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs got start=%b data=%h busy=%b ovr=%b want all 0",
                     tx_start, tx_data, busy, overrun);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [7] = '{8'h30, 8'h39, 8'h52, 8'h30, 8'h34, 8'h0D, 8'h0A};
        int base = rx_q.size();
        bit ok;
        start_line({6'd4, 6'd9});
        checks++;
        if (busy !== 1'b1 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency1 got busy=%b start=%b want busy=1 start=0", busy, tx_start);
        end
        @(posedge clk);
        #1;
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h30) begin
            errors++;
            $display("FAIL basic_first_start got start=%b data=%h want 1 30", tx_start, tx_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (tx_start !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width got start=%b want 0", tx_start);
        end
        wait_idle(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL basic_timeout got busy=%b want 0", busy);
        end
        checks++;
        if (rx_q.size() - base !== 7) begin
            errors++;
            $display("FAIL basic_count got %0d want 7", rx_q.size() - base);
        end
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (rx_q[base+i] !== exp[i]) begin
                errors++;
                $display("FAIL basic_byte%0d got %h want %h", i, rx_q[base+i], exp[i]);
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL basic_overrun got %b want 0", overrun);
        end
    endtask

    task automatic test_patterns();
        logic [11:0] pat [2] = '{12'hFFF, 12'h000};
        logic [7:0]  exp [2][7] = '{'{8'h33, 8'h46, 8'h52, 8'h33, 8'h46, 8'h0D, 8'h0A},
                                    '{8'h30, 8'h30, 8'h52, 8'h30, 8'h30, 8'h0D, 8'h0A}};
        bit ok;
        for (int p = 0; p < 2; p++) begin
            int base = rx_q.size();
            start_line(pat[p]);
            wait_idle(ok);
            checks++;
            if (!ok || rx_q.size() - base !== 7) begin
                errors++;
                $display("FAIL pattern%0d_count got %0d ok=%b want 7", p, rx_q.size() - base, ok);
            end else begin
                for (int i = 0; i < 7; i++) begin
                    checks++;
                    if (rx_q[base+i] !== exp[p][i]) begin
                        errors++;
                        $display("FAIL pattern%0d_byte%0d got %h want %h", p, i, rx_q[base+i], exp[p][i]);
                    end
                end
            end
        end
    endtask

    task automatic test_letter_boundary();
        logic [7:0] exp [7] = '{8'h30, 8'h41, 8'h52, 8'h33, 8'h39, 8'h0D, 8'h0A};
        int base = rx_q.size();
        bit ok;
        start_line({6'h39, 6'h0A});
        wait_idle(ok);
        checks++;
        if (!ok || rx_q.size() - base !== 7) begin
            errors++;
            $display("FAIL letter_count got %0d ok=%b want 7", rx_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (rx_q[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL letter_byte%0d got %h want %h", i, rx_q[base+i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [7:0] exp [7] = '{8'h30, 8'h43, 8'h52, 8'h31, 8'h46, 8'h0D, 8'h0A};
        int base = rx_q.size();
        int p0 = pulses;
        bit ok;
        hold_busy = 1'b1;
        start_line({6'h1F, 6'h0C});
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (pulses !== p0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got pulses=%0d busy=%b want %0d 1", pulses - p0, busy, 0);
        end
        ack_dly   = 5;
        hold_busy = 1'b0;
        wait_idle(ok);
        ack_dly   = 1;
        checks++;
        if (!ok || pulses - p0 !== 7 || rx_q.size() - base !== 7) begin
            errors++;
            $display("FAIL bp_pulses got %0d bytes %0d ok=%b want 7", pulses - p0, rx_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (rx_q[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL bp_byte%0d got %h want %h", i, rx_q[base+i], exp[i]);
                end
            end
        end
        checks++;
        if (stab_viol !== 0 || pulse_viol !== 0) begin
            errors++;
            $display("FAIL bp_protocol got stab=%0d pulse=%0d want 0 0", stab_viol, pulse_viol);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_a [7] = '{8'h32, 8'h45, 8'h52, 8'h31, 8'h32, 8'h0D, 8'h0A};
        logic [7:0] exp_b [7] = '{8'h33, 8'h30, 8'h52, 8'h30, 8'h37, 8'h0D, 8'h0A};
        int base = rx_q.size();
        bit ok;
        start_line({6'h12, 6'h2E});
        wait_rx(base + 3, ok);
        start_line({6'h07, 6'h30});
        wait_idle(ok);
        checks++;
        if (!ok || rx_q.size() - base !== 7) begin
            errors++;
            $display("FAIL ovr_count got %0d ok=%b want 7", rx_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (rx_q[base+i] !== exp_a[i]) begin
                    errors++;
                    $display("FAIL ovr_a_byte%0d got %h want %h", i, rx_q[base+i], exp_a[i]);
                end
            end
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL ovr_set got %b want 1", overrun);
        end
        repeat (5) @(posedge clk);
        base = rx_q.size();
        start_line({6'h07, 6'h30});
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_clear got %b want 0", overrun);
        end
        wait_idle(ok);
        checks++;
        if (!ok || rx_q.size() - base !== 7) begin
            errors++;
            $display("FAIL ovr_b_count got %0d ok=%b want 7", rx_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (rx_q[base+i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL ovr_b_byte%0d got %h want %h", i, rx_q[base+i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_line();
        logic [7:0] exp [7] = '{8'h32, 8'h37, 8'h52, 8'h31, 8'h36, 8'h0D, 8'h0A};
        int base = rx_q.size();
        bit ok;
        start_line({6'h3B, 6'h15});
        wait_rx(base + 2, ok);
        start_line(12'h000);
        wait_rx(base + 4, ok);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1 || tx_data !== 8'h33) begin
            errors++;
            $display("FAIL rst_pre got ovr=%b busy=%b data=%h want 1 1 33", overrun, busy, tx_data);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if ({tx_start, tx_data, busy, overrun} !== 11'h000) begin
            errors++;
            $display("FAIL rst_async got start=%b data=%h busy=%b ovr=%b want all 0",
                     tx_start, tx_data, busy, overrun);
        end
        repeat (30) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (rx_q.size() - base !== 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort got bytes=%0d busy=%b want 4 0", rx_q.size() - base, busy);
        end
        base = rx_q.size();
        start_line(12'h5A7);
        wait_idle(ok);
        checks++;
        if (!ok || rx_q.size() - base !== 7) begin
            errors++;
            $display("FAIL rst_after_count got %0d ok=%b want 7", rx_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (rx_q[base+i] !== exp[i]) begin
                    errors++;
                    $display("FAIL rst_after_byte%0d got %h want %h", i, rx_q[base+i], exp[i]);
                end
            end
        end
        checks++;
        if (pulse_viol !== 0) begin
            errors++;
            $display("FAIL pulse_protocol got %0d want 0", pulse_viol);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        n_rst     = 1'b0;
        alu_done  = 1'b0;
        result    = 12'h000;
        hold_busy = 1'b0;
        ack_dly   = 1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        test_basic();
        test_patterns();
        test_letter_boundary();
        test_back_pressure();
        test_overrun();
        test_reset_mid_line();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
